// File: rtl/led_pulse_stretch_pkg.sv
// Shared types and constants for the LED pulse stretcher.
package led_pulse_stretch_pkg;

   localparam int unsigned DUR_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_OFF  = 2'd2
   } led_state_e;

endpackage

// File: rtl/led_pulse_stretch.sv
// Stretches short event pulses into human-visible LED blinks with a guaranteed
// off gap, queueing events that arrive while a blink is in progress.
module led_pulse_stretch
   import led_pulse_stretch_pkg::*;
#(
   parameter int unsigned ON_COUNT  = 2_000_000,
   parameter int unsigned OFF_COUNT = 2_000_000,
   parameter int unsigned PEND_W    = 4
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic              i_pulse,
   output logic              o_led,
   output logic              o_busy,
   output logic [PEND_W-1:0] o_pending,
   output logic              o_overflow
);

   localparam logic [DUR_W-1:0]  ON_LAST   = DUR_W'(ON_COUNT - 1);
   localparam logic [DUR_W-1:0]  OFF_LAST  = DUR_W'(OFF_COUNT - 1);
   localparam logic [PEND_W-1:0] PEND_MAX  = '1;

   led_state_e        state_q, state_d;
   logic [DUR_W-1:0]  cnt_q, cnt_d;
   logic [PEND_W-1:0] pend_q, pend_d;
   logic              ovf_q, ovf_d;
   logic              pulse_q;
   logic              led_q, led_d;
   logic              busy_q, busy_d;
   logic              evt;
   logic              off_end;

   assign evt     = i_pulse & ~pulse_q;
   assign off_end = (state_q == ST_OFF) && (cnt_q == OFF_LAST);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + DUR_W'(1);
      pend_d  = pend_q;
      ovf_d   = ovf_q;

      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (evt) state_d = ST_ON;
         end
         ST_ON: begin
            if (cnt_q == ON_LAST) begin
               state_d = ST_OFF;
               cnt_d   = '0;
            end
         end
         ST_OFF: begin
            if (off_end) begin
               cnt_d   = '0;
               state_d = ((pend_q != '0) || evt) ? ST_ON : ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      // An event on the OFF-end edge cancels the decrement (net +1-1).
      if (off_end) begin
         if ((pend_q != '0) && !evt) pend_d = pend_q - 1'b1;
      end else if (evt && (state_q != ST_IDLE)) begin
         if (pend_q == PEND_MAX) ovf_d  = 1'b1;
         else                    pend_d = pend_q + 1'b1;
      end

      led_d  = (state_d == ST_ON);
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
         pulse_q <= 1'b0;
         led_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         pulse_q <= i_pulse;
         led_q   <= led_d;
         busy_q  <= busy_d;
      end
   end

   assign o_led      = led_q;
   assign o_busy     = busy_q;
   assign o_pending  = pend_q;
   assign o_overflow = ovf_q;

endmodule

// File: tb/tb_led_pulse_stretch.sv
// Directed table-driven bench for led_pulse_stretch (ON=4, OFF=3, PEND_W=2).
module tb_led_pulse_stretch;

   logic       clk;
   logic       rstn;
   logic       pulse;
   logic       led;
   logic       busy;
   logic [1:0] pending;
   logic       overflow;

   int unsigned n_checks;
   int unsigned n_fail;

   typedef struct {
      logic       p;
      logic       led;
      logic       busy;
      logic [1:0] pend;
      logic       ovf;
   } vec_t;

   vec_t vq[$];

   led_pulse_stretch #(
      .ON_COUNT (4),
      .OFF_COUNT(3),
      .PEND_W   (2)
   ) dut (
      .i_clk     (clk),
      .i_rstn    (rstn),
      .i_pulse   (pulse),
      .o_led     (led),
      .o_busy    (busy),
      .o_pending (pending),
      .o_overflow(overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic l, input logic b,
                          input logic [1:0] pd, input logic o);
      chk({tag, ".led"},      int'(led),      int'(l));
      chk({tag, ".busy"},     int'(busy),     int'(b));
      chk({tag, ".pending"},  int'(pending),  int'(pd));
      chk({tag, ".overflow"}, int'(overflow), int'(o));
   endtask

   function automatic void add(input logic p, input logic l, input logic b,
                               input logic [1:0] pd, input logic o, input int unsigned n);
      vec_t v;
      v.p = p; v.led = l; v.busy = b; v.pend = pd; v.ovf = o;
      for (int unsigned k = 0; k < n; k++) vq.push_back(v);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int unsigned led_hi;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rstn     = 1'b0;
      pulse    = 1'b0;
      #2;
      chk_all("reset", 1'b0, 1'b0, 2'd0, 1'b0);
      step();
      step();
      chk_all("reset_held", 1'b0, 1'b0, 2'd0, 1'b0);
      @(negedge clk);
      rstn = 1'b1;
      step();

      // single 1-cycle pulse from IDLE
      add(1, 1, 1, 0, 0, 1); add(0, 1, 1, 0, 0, 3); add(0, 0, 1, 0, 0, 3);
      add(0, 0, 0, 0, 0, 2);
      // held high for 20 cycles -> one blink
      add(1, 1, 1, 0, 0, 4); add(1, 0, 1, 0, 0, 3); add(1, 0, 0, 0, 0, 13);
      add(0, 0, 0, 0, 0, 1);
      // three extra events while busy -> pending 1,2,3, four blinks
      add(1, 1, 1, 0, 0, 1); add(0, 1, 1, 0, 0, 1); add(1, 1, 1, 1, 0, 1);
      add(0, 1, 1, 1, 0, 1); add(1, 0, 1, 2, 0, 1); add(0, 0, 1, 2, 0, 1);
      add(1, 0, 1, 3, 0, 1); add(0, 1, 1, 2, 0, 4); add(0, 0, 1, 2, 0, 3);
      add(0, 1, 1, 1, 0, 4); add(0, 0, 1, 1, 0, 3); add(0, 1, 1, 0, 0, 4);
      add(0, 0, 1, 0, 0, 3); add(0, 0, 0, 0, 0, 1);
      // event coincident with OFF end while pending=1
      add(1, 1, 1, 0, 0, 1); add(0, 1, 1, 0, 0, 1); add(1, 1, 1, 1, 0, 1);
      add(0, 1, 1, 1, 0, 1); add(0, 0, 1, 1, 0, 3); add(1, 1, 1, 1, 0, 1);
      add(0, 1, 1, 1, 0, 3); add(0, 0, 1, 1, 0, 3); add(0, 1, 1, 0, 0, 4);
      add(0, 0, 1, 0, 0, 3); add(0, 0, 0, 0, 0, 1);
      // event on the OFF-to-IDLE edge restarts a blink
      add(1, 1, 1, 0, 0, 1); add(0, 1, 1, 0, 0, 3); add(0, 0, 1, 0, 0, 3);
      add(1, 1, 1, 0, 0, 1); add(0, 1, 1, 0, 0, 3); add(0, 0, 1, 0, 0, 3);
      add(0, 0, 0, 0, 0, 1);
      // saturation: sixth event dropped, overflow sticks; ends mid-ON
      add(1, 1, 1, 0, 0, 1); add(0, 1, 1, 0, 0, 1); add(1, 1, 1, 1, 0, 1);
      add(0, 1, 1, 1, 0, 1); add(1, 0, 1, 2, 0, 1); add(0, 0, 1, 2, 0, 1);
      add(1, 0, 1, 3, 0, 1); add(0, 1, 1, 2, 0, 1); add(1, 1, 1, 3, 0, 1);
      add(0, 1, 1, 3, 0, 1); add(1, 1, 1, 3, 1, 1); add(0, 0, 1, 3, 1, 3);
      add(0, 1, 1, 2, 1, 2);

      for (int unsigned i = 0; i < vq.size(); i++) begin
         string tag;
         pulse = vq[i].p;
         step();
         tag = $sformatf("vec%0d", i);
         chk_all(tag, vq[i].led, vq[i].busy, vq[i].pend, vq[i].ovf);
      end

      // asynchronous reset mid-ON clears everything, no residual blink
      #2;
      rstn = 1'b0;
      #1;
      chk_all("async_rst", 1'b0, 1'b0, 2'd0, 1'b0);
      step();
      @(negedge clk);
      rstn = 1'b1;
      led_hi = 0;
      for (int unsigned k = 0; k < 10; k++) begin
         step();
         if (led) led_hi++;
      end
      chk("no_residual_blink", led_hi, 0);
      chk_all("post_rst_idle", 1'b0, 1'b0, 2'd0, 1'b0);

      // pulse already high when reset releases counts as an event
      rstn  = 1'b0;
      pulse = 1'b1;
      step();
      @(negedge clk);
      rstn = 1'b1;
      step();
      chk_all("rel_high_evt", 1'b1, 1'b1, 2'd0, 1'b0);
      pulse  = 1'b0;
      led_hi = 1;
      for (int unsigned k = 0; k < 12; k++) begin
         step();
         if (led) led_hi++;
      end
      chk("rel_high_blink_len", led_hi, 4);
      chk_all("rel_high_done", 1'b0, 1'b0, 2'd0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
